sync_fifo_ctrl: RTL



---
 rtl/sync_fifo_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/sync_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// sync_fifo_ctrl
//
// Single-clock FIFO with integrated register-array storage and pointer control.
// Reports occupancy (LEVEL) and almost-full/almost-empty flags against
// programmable thresholds. It also keeps sticky overflow/underflow error flags,
// supports a synchronous flush, and offers a show-ahead or registered read port.
//
// Ports
//   CLK           clock, all state updates on the rising edge
//   RST           asynchronous reset, active low
//   FLUSH         synchronous flush: pointers to 0, requests in the same cycle ignored
//   WR_EN/WR_DATA write request and word
//   RD_EN         read request (pops the head word)
//   ERR_CLR       clears OVERFLOW/UNDERFLOW (a simultaneous set event wins)
//   RD_DATA       read word (show-ahead head or registered, see RD_REG)
//   RD_VALID      RD_DATA qualifier
//   FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY  status flags from registered state
//   LEVEL         occupancy 0..DEPTH
//   OVERFLOW, UNDERFLOW  sticky error flags
// -----------------------------------------------------------------------------
module sync_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 14,
  parameter int AE_LEVEL   = 2,
  parameter int RD_REG     = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  FLUSH,
  input  logic                  WR_EN,
  input  logic [DATA_WIDTH-1:0] WR_DATA,
  input  logic                  RD_EN,
  input  logic                  ERR_CLR,
  output logic [DATA_WIDTH-1:0] RD_DATA,
  output logic                  RD_VALID,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  ALMOST_FULL,
  output logic                  ALMOST_EMPTY,
  output logic [ADDR_WIDTH:0]   LEVEL,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam int PW = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic                  ovf_q, ovf_d;
  logic                  udf_q, udf_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_vld_q, rd_vld_d;

  logic                  full, empty;
  logic [PW-1:0]         level;
  logic [DATA_WIDTH-1:0] head_word;
  logic                  wr_acc, rd_acc;

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the array indices coincide.
  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]) &&
                     (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]);
  assign level     = wptr_q - rptr_q;
  assign head_word = mem_q[rptr_q[ADDR_WIDTH-1:0]];

  // Acceptance is judged on the flags before the edge; flush overrides both.
  assign wr_acc = WR_EN & ~full  & ~FLUSH;
  assign rd_acc = RD_EN & ~empty & ~FLUSH;

  always_comb begin
    mem_d     = mem_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    ovf_d     = ovf_q;
    udf_d     = udf_q;
    rd_data_d = rd_data_q;
    rd_vld_d  = 1'b0;
    if (FLUSH) begin
      // Memory and error flags are left untouched; only the pointers rewind.
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (wr_acc) begin
        mem_d[wptr_q[ADDR_WIDTH-1:0]] = WR_DATA;
        wptr_d = wptr_q + PW'(1);
      end
      if (rd_acc) begin
        rptr_d    = rptr_q + PW'(1);
        rd_data_d = head_word;
        rd_vld_d  = 1'b1;
      end
      // Set has priority over clear when both happen in one cycle.
      if (WR_EN & full)      ovf_d = 1'b1;
      else if (ERR_CLR)      ovf_d = 1'b0;
      if (RD_EN & empty)     udf_d = 1'b1;
      else if (ERR_CLR)      udf_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
    end
  end

  assign FULL         = full;
  assign EMPTY        = empty;
  assign LEVEL        = level;
  assign ALMOST_FULL  = (level >= PW'(AF_LEVEL));
  assign ALMOST_EMPTY = (level <= PW'(AE_LEVEL));
  assign OVERFLOW     = ovf_q;
  assign UNDERFLOW    = udf_q;
  // Show-ahead mode presents the head word directly; registered mode presents
  // the word captured by the last accepted read.
  assign RD_DATA      = (RD_REG != 0) ? rd_data_q : head_word;
  assign RD_VALID     = (RD_REG != 0) ? rd_vld_q  : ~empty;

endmodule
